// File: rtl/ov5640_init_sequencer.sv
// OV5640 bring-up controller: drives the power-down/reset pins through the power-up
// timing, then replays a ROM register table to the SCCB engine with NACK retry.
module ov5640_init_sequencer #(
  parameter int TBL_LEN       = 256,
  parameter int PWDN_CYCLES   = 100000,
  parameter int RST_CYCLES    = 100000,
  parameter int SETTLE_CYCLES = 2000000,
  parameter int DELAY_UNIT    = 100000,
  parameter int MAX_RETRY     = 3,
  localparam int AW = (TBL_LEN > 1) ? $clog2(TBL_LEN) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          setup_start,
  output logic          ov5640_pwdn,
  output logic          ov5640_rstb,
  output logic [AW-1:0] tbl_addr,
  input  logic [23:0]   tbl_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [15:0]   cmd_addr,
  output logic [7:0]    cmd_data,
  input  logic          cmd_done,
  input  logic          cmd_nack,
  output logic          setup_busy,
  output logic          setup_done,
  output logic          setup_fail,
  output logic [AW-1:0] fail_index
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PWDN   = 4'd1;
  localparam logic [3:0] S_RST    = 4'd2;
  localparam logic [3:0] S_SETTLE = 4'd3;
  localparam logic [3:0] S_FETCH  = 4'd4;
  localparam logic [3:0] S_LOAD   = 4'd5;
  localparam logic [3:0] S_ISSUE  = 4'd6;
  localparam logic [3:0] S_WAIT   = 4'd7;
  localparam logic [3:0] S_DELAY  = 4'd8;
  localparam logic [3:0] S_NEXT   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;
  localparam logic [3:0] S_FAIL   = 4'd11;

  // Phase timers compare against the last cycle so each phase lasts exactly N cycles.
  localparam logic [31:0]   PWDN_LAST   = 32'(PWDN_CYCLES - 1);
  localparam logic [31:0]   RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   DELAY_LEN   = 32'(DELAY_UNIT);
  localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRY);
  localparam logic [AW-1:0] LAST_IDX    = AW'(TBL_LEN - 1);

  logic [3:0]  state;
  logic [31:0] timer;
  logic [7:0]  retry;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry       <= '0;
      ov5640_pwdn <= 1'b1;
      ov5640_rstb <= 1'b0;
      tbl_addr    <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      setup_busy  <= 1'b0;
      setup_done  <= 1'b0;
      setup_fail  <= 1'b0;
      fail_index  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (setup_start) begin
            state       <= S_PWDN;
            timer       <= '0;
            setup_done  <= 1'b0;
            setup_fail  <= 1'b0;
            setup_busy  <= 1'b1;
            ov5640_pwdn <= 1'b1;
            ov5640_rstb <= 1'b0;
          end
        end
        S_PWDN: begin
          if (timer == PWDN_LAST) begin
            timer       <= '0;
            ov5640_pwdn <= 1'b0;
            state       <= S_RST;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_RST: begin
          if (timer == RST_LAST) begin
            timer       <= '0;
            ov5640_rstb <= 1'b1;
            state       <= S_SETTLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer    <= '0;
            tbl_addr <= '0;
            state    <= S_FETCH;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          retry <= '0;
          // Address FFFF marks a pause entry; its data byte is the delay in units.
          if (tbl_data[23:8] == 16'hFFFF) begin
            if (tbl_data[7:0] == 8'd0) begin
              state <= S_NEXT;
            end else begin
              timer <= {24'd0, tbl_data[7:0]} * DELAY_LEN;
              state <= S_DELAY;
            end
          end else begin
            cmd_addr  <= tbl_data[23:8];
            cmd_data  <= tbl_data[7:0];
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            if (!cmd_nack) begin
              state <= S_NEXT;
            end else if (retry < RETRY_MAX) begin
              retry     <= retry + 8'd1;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              fail_index <= tbl_addr;
              setup_fail <= 1'b1;
              setup_busy <= 1'b0;
              state      <= S_FAIL;
            end
          end
        end
        S_DELAY: begin
          if (timer <= 32'd1) state <= S_NEXT;
          else                timer <= timer - 32'd1;
        end
        S_NEXT: begin
          if (tbl_addr == LAST_IDX) begin
            setup_done <= 1'b1;
            setup_busy <= 1'b0;
            state      <= S_DONE;
          end else begin
            tbl_addr <= tbl_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Bench for ov5640_init_sequencer: behavioural ROM and SCCB engine, table-driven runs
// plus hand-written reset, ignored-start and restart sequences.
module tb_ov5640_init_sequencer;

  localparam int TBL_LEN  = 3;
  localparam int DONE_LAT = 5;
  localparam int TMO      = 1000;
  localparam logic [23:0] W0 = 24'h300882;
  localparam logic [23:0] W1 = 24'h310303;
  localparam logic [23:0] W2 = 24'h430030;
  localparam logic [23:0] D5 = 24'hFFFF05;
  localparam logic [23:0] D0 = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        setup_start = 1'b0;
  logic        ov5640_pwdn, ov5640_rstb;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_done = 1'b0;
  logic        cmd_nack = 1'b0;
  logic        setup_busy, setup_done, setup_fail;
  logic [1:0]  fail_index;

  always #5 clk = ~clk;

  ov5640_init_sequencer #(
    .TBL_LEN(TBL_LEN), .PWDN_CYCLES(4), .RST_CYCLES(4), .SETTLE_CYCLES(8),
    .DELAY_UNIT(10), .MAX_RETRY(3)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .setup_start(setup_start),
    .ov5640_pwdn(ov5640_pwdn), .ov5640_rstb(ov5640_rstb),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .setup_busy(setup_busy), .setup_done(setup_done), .setup_fail(setup_fail),
    .fail_index(fail_index)
  );

  typedef struct packed {
    logic [23:0]       r0, r1, r2;
    int                stall;
    int                nacks;
    int                nwr;
    logic [0:4][23:0]  wr;
    logic              done;
    logic              fail;
    logic [1:0]        fidx;
    int                gap;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_edge = 0;
  int timed_out = 0;

  // stimulus-side knobs (written only by the initial block)
  logic [23:0] rom [0:3];
  int          stall_req = 0;
  int          nack_cfg = 0;
  logic        clear = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // SCCB engine model: ready after stall_req cycles of valid, done DONE_LAT cycles later
  int   stall_cnt = 0;
  int   done_cnt = 0;
  int   nacks_given = 0;
  logic pend_nack = 1'b0;
  assign cmd_ready = (stall_cnt >= stall_req);

  always @(posedge clk) begin
    cmd_done <= 1'b0;
    cmd_nack <= 1'b0;
    if (!sys_rst || clear) begin
      stall_cnt   <= 0;
      done_cnt    <= 0;
      nacks_given <= 0;
      pend_nack   <= 1'b0;
    end else begin
      if (done_cnt == 1) begin
        cmd_done <= 1'b1;
        cmd_nack <= pend_nack;
        done_cnt <= 0;
      end else if (done_cnt > 1) begin
        done_cnt <= done_cnt - 1;
      end
      if (cmd_valid && cmd_ready) begin
        stall_cnt <= 0;
        done_cnt  <= DONE_LAT;
        if (cmd_addr == 16'h3103 && nacks_given < nack_cfg) begin
          pend_nack   <= 1'b1;
          nacks_given <= nacks_given + 1;
        end else begin
          pend_nack <= 1'b0;
        end
      end else if (cmd_valid) begin
        stall_cnt <= stall_cnt + 1;
      end
    end
  end

  // Monitor sampled on the falling edge: event cycles, write log, handshake stability
  int          busy_rise, pwdn_fall, rstb_rise, rise_n, wr_n, hold_n, viol_n, pwdn_rise_n;
  int          rise_cyc [16];
  logic [23:0] wr_log [16];
  logic        prev_busy = 1'b0, prev_pwdn = 1'b1, prev_rstb = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [23:0] prev_word = '0;

  always @(negedge clk) begin
    if (clear) begin
      busy_rise <= -1; pwdn_fall <= -1; rstb_rise <= -1;
      rise_n <= 0; wr_n <= 0; hold_n <= 0; viol_n <= 0; pwdn_rise_n <= 0;
    end else begin
      if (!prev_busy && setup_busy) busy_rise <= cyc;
      if (prev_pwdn && !ov5640_pwdn) pwdn_fall <= cyc;
      if (!prev_pwdn && ov5640_pwdn) pwdn_rise_n <= pwdn_rise_n + 1;
      if (!prev_rstb && ov5640_rstb) rstb_rise <= cyc;
      if (!prev_valid && cmd_valid && rise_n < 16) begin
        rise_cyc[rise_n] <= cyc;
        rise_n <= rise_n + 1;
      end
      if (cmd_valid && cmd_ready && wr_n < 16) begin
        wr_log[wr_n] <= {cmd_addr, cmd_data};
        wr_n <= wr_n + 1;
      end
      if (cmd_valid && !cmd_ready) hold_n <= hold_n + 1;
      if (prev_valid && !prev_ready && (!cmd_valid || {cmd_addr, cmd_data} != prev_word))
        viol_n <= viol_n + 1;
    end
    prev_busy  <= setup_busy;
    prev_pwdn  <= ov5640_pwdn;
    prev_rstb  <= ov5640_rstb;
    prev_valid <= cmd_valid;
    prev_ready <= cmd_ready;
    prev_word  <= {cmd_addr, cmd_data};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulseStart();
    start_edge  = cyc + 1;
    setup_start = 1'b1;
    @(negedge clk);
    setup_start = 1'b0;
  endtask

  task automatic waitEnd();
    timed_out = 1;
    for (int i = 0; i < TMO; i++) begin
      if (setup_done || setup_fail) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    rom[0] = v.r0; rom[1] = v.r1; rom[2] = v.r2; rom[3] = '0;
    stall_req = v.stall;
    nack_cfg  = v.nacks;
    clearLogs();
    pulseStart();
    waitEnd();
  endtask

  task automatic checkScenario(input vec_t v, input int k);
    checkOutput($sformatf("v%0d_timeout", k), timed_out, 0);
    checkOutput($sformatf("v%0d_busy_rise", k), busy_rise - start_edge, 0);
    checkOutput($sformatf("v%0d_pwdn_fall", k), pwdn_fall - start_edge, 4);
    checkOutput($sformatf("v%0d_rstb_rise", k), rstb_rise - start_edge, 8);
    checkOutput($sformatf("v%0d_first_valid", k), rise_cyc[0] - start_edge, 18);
    checkOutput($sformatf("v%0d_gap", k), rise_cyc[1] - rise_cyc[0], v.gap);
    checkOutput($sformatf("v%0d_writes", k), wr_n, v.nwr);
    for (int i = 0; i < v.nwr && i < 5; i++)
      checkOutput($sformatf("v%0d_write%0d", k, i), {8'd0, wr_log[i]}, {8'd0, v.wr[i]});
    checkOutput($sformatf("v%0d_done", k), {31'd0, setup_done}, {31'd0, v.done});
    checkOutput($sformatf("v%0d_fail", k), {31'd0, setup_fail}, {31'd0, v.fail});
    checkOutput($sformatf("v%0d_busy", k), {31'd0, setup_busy}, 0);
    if (v.fail) checkOutput($sformatf("v%0d_fail_index", k), {30'd0, fail_index}, {30'd0, v.fidx});
    checkOutput($sformatf("v%0d_hold", k), hold_n, v.stall * v.nwr);
    checkOutput($sformatf("v%0d_stability", k), viol_n, 0);
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "_pwdn"}, {31'd0, ov5640_pwdn}, 1);
    checkOutput({p, "_rstb"}, {31'd0, ov5640_rstb}, 0);
    checkOutput({p, "_valid"}, {31'd0, cmd_valid}, 0);
    checkOutput({p, "_cmd"}, {8'd0, cmd_addr, cmd_data}, 0);
    checkOutput({p, "_tbl_addr"}, {30'd0, tbl_addr}, 0);
    checkOutput({p, "_flags"}, {29'd0, setup_busy, setup_done, setup_fail}, 0);
    checkOutput({p, "_fail_index"}, {30'd0, fail_index}, 0);
  endtask

  function automatic vec_t mk(input logic [23:0] r0, r1, r2, input int stall, nacks, nwr,
                              input logic [23:0] w0, w1, w2, w3, w4,
                              input logic done, fail, input logic [1:0] fidx, input int gap);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.stall = stall; v.nacks = nacks; v.nwr = nwr;
    v.wr = {w0, w1, w2, w3, w4};
    v.done = done; v.fail = fail; v.fidx = fidx; v.gap = gap;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    // gap = cycles between the first two cmd_valid rises
    vecs[0] = mk(W0, W1, W2, 0, 0, 3, W0, W1, W2, 0, 0, 1, 0, 0, 10);
    vecs[1] = mk(W0, W1, W2, 7, 0, 3, W0, W1, W2, 0, 0, 1, 0, 0, 17);
    vecs[2] = mk(W0, W1, W2, 0, 2, 5, W0, W1, W1, W1, W2, 1, 0, 0, 10);
    vecs[3] = mk(W0, W1, W2, 0, 4, 5, W0, W1, W1, W1, W1, 0, 1, 1, 10);
    vecs[4] = mk(W0, D5, W2, 0, 0, 2, W0, W2, 0, 0, 0, 1, 0, 0, 63);
    vecs[5] = mk(W0, D0, W2, 0, 0, 2, W0, W2, 0, 0, 0, 1, 0, 0, 13);
    for (int i = 0; i < 4; i++) rom[i] = '0;

    // reset with a start request in the final reset cycle
    repeat (3) @(negedge clk);
    setup_start = 1'b1;
    @(negedge clk);
    checkResetValues("por");
    sys_rst = 1'b1;
    setup_start = 1'b0;
    @(negedge clk);
    checkOutput("por_start_ignored", {31'd0, setup_busy}, 0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      checkScenario(vecs[k], k);
    end

    // reset while a write is held in ISSUE
    rom[0] = W0; rom[1] = W1; rom[2] = W2;
    stall_req = 100000;
    nack_cfg  = 0;
    clearLogs();
    pulseStart();
    for (int i = 0; i < 100 && !cmd_valid; i++) @(negedge clk);
    checkOutput("rst_in_issue", {31'd0, cmd_valid}, 1);
    sys_rst = 1'b0;
    setup_start = 1'b1;
    @(negedge clk);
    sys_rst = 1'b1;
    setup_start = 1'b0;
    checkResetValues("midrst");
    @(negedge clk);
    checkOutput("midrst_idle", {31'd0, setup_busy}, 0);
    applyStimulus(vecs[0]);
    checkScenario(vecs[0], 6);

    // start during WAIT is ignored
    stall_req = 0;
    clearLogs();
    pulseStart();
    for (int i = 0; i < 100 && !(wr_n >= 1 && !cmd_valid); i++) @(negedge clk);
    checkOutput("wait_reached", {31'd0, cmd_valid}, 0);
    pulseStart();
    waitEnd();
    checkOutput("wait_start_writes", wr_n, 3);
    checkOutput("wait_start_pwdn_rises", pwdn_rise_n, 1);
    checkOutput("wait_start_done", {31'd0, setup_done}, 1);

    // start in DONE restarts the whole power-up sequence
    clearLogs();
    pulseStart();
    checkOutput("restart_pwdn", {31'd0, ov5640_pwdn}, 1);
    checkOutput("restart_rstb", {31'd0, ov5640_rstb}, 0);
    checkOutput("restart_busy", {31'd0, setup_busy}, 1);
    checkOutput("restart_done_clr", {31'd0, setup_done}, 0);
    waitEnd();
    checkOutput("restart_timeout", timed_out, 0);
    checkOutput("restart_writes", wr_n, 3);
    checkOutput("restart_pwdn_fall", pwdn_fall - start_edge, 4);
    checkOutput("restart_done", {31'd0, setup_done}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov5640_init_sequencer.md
# ov5640_init_sequencer

Power-up and register-table sequencer for the OV5640 camera. On a start pulse it drives the sensor power-down and reset pins through the datasheet power-up timing. It then walks a register table held in a synchronous ROM and issues one 16-bit-address / 8-bit-data write per entry to the SCCB write engine over a valid/ready/done handshake, retrying NACKed writes. It sits between the top-level camera master and the SCCB engine, replacing fixed-timer setup with a table-driven, error-reporting controller.

## Interface
- TBL_LEN, 256: number of table entries, indices 0..TBL_LEN-1; TBL_LEN ≥ 1.
- PWDN_CYCLES, 100000: cycles `ov5640_pwdn` stays high after start.
- RST_CYCLES, 100000: cycles `ov5640_rstb` stays low after pwdn release.
- SETTLE_CYCLES, 2000000: cycles waited after reset release before the first SCCB write.
- DELAY_UNIT, 100000: cycles per unit of a delay entry.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- sys_clk  in  1  single clock, rising edge.
- sys_rst  in  1  reset: synchronous, active-low.
- setup_start  in  1  one-cycle start request; ignored unless the sequencer is in IDLE, DONE or FAIL.
- ov5640_pwdn  out  1  sensor power-down, active-high.
- ov5640_rstb  out  1  sensor reset, active-low.
- tbl_addr  out  clog2(TBL_LEN)  ROM index.
- tbl_data  in  24  ROM word {reg_addr[15:0], reg_data[7:0]}, valid one cycle after `tbl_addr` changes.
- cmd_valid  out  1  write request to the SCCB engine.
- cmd_ready  in  1  engine accepts; transfer occurs when `cmd_valid` & `cmd_ready`.
- cmd_addr  out  16  register address, stable while `cmd_valid` is high.
- cmd_data  out  8  register data, stable while `cmd_valid` is high.
- cmd_done  in  1  one-cycle pulse: the engine finished the accepted write.
- cmd_nack  in  1  qualified by `cmd_done`: the slave did not acknowledge.
- setup_busy  out  1  high from the accepted start until DONE or FAIL.
- setup_done  out  1  level, high in DONE.
- setup_fail  out  1  level, high in FAIL.
- fail_index  out  clog2(TBL_LEN)  table index of the failing entry; valid in FAIL.

## Operation
- Reset values: `ov5640_pwdn`=1, `ov5640_rstb`=0, `cmd_valid`=0, `cmd_addr`=0, `cmd_data`=0, `tbl_addr`=0, `setup_busy`=0, `setup_done`=0, `setup_fail`=0, `fail_index`=0, state IDLE, counters 0.
- IDLE: `setup_start` → PWDN. On entry, clear `setup_done`/`setup_fail`, set `setup_busy`, `pwdn`=1, `rstb`=0.
- PWDN: count PWDN_CYCLES, then `pwdn`=0 → RST.
- RST: count RST_CYCLES, then `rstb`=1 → SETTLE.
- SETTLE: count SETTLE_CYCLES, then set `tbl_addr`=0 → FETCH.
- FETCH: one wait cycle for ROM latency → LOAD.
- LOAD: capture `tbl_data` and clear the retry counter.
  - If reg_addr = 16'hFFFF (delay entry), load delay = reg_data × DELAY_UNIT → DELAY. If reg_data = 0, go directly to NEXT.
  - Otherwise drive `cmd_addr`/`cmd_data`, assert `cmd_valid` → ISSUE.
- ISSUE: hold `cmd_valid` and payload until `cmd_ready`; on handshake deassert `cmd_valid` → WAIT.
- WAIT: on `cmd_done`:
  - `cmd_nack`=0 → NEXT.
  - `cmd_nack`=1 and retries < MAX_RETRY → increment retries, reassert `cmd_valid` with the same payload → ISSUE.
  - Otherwise set `fail_index`=`tbl_addr`, `setup_fail`=1, `setup_busy`=0 → FAIL.
- DELAY: count down to 0 → NEXT. The delay counter is wide enough for 255×DELAY_UNIT.
- NEXT: if `tbl_addr` = TBL_LEN-1, set `setup_done`=1, `setup_busy`=0 → DONE. Otherwise increment `tbl_addr` → FETCH. `tbl_addr` never wraps past TBL_LEN-1.
- DONE and FAIL: the sensor pins keep their values (`pwdn`=0, `rstb`=1). `setup_start` restarts from PWDN, which re-asserts `pwdn`=1 and `rstb`=0.
- `setup_start` in any other state is ignored. It has no effect in the same cycle as reset.
- `cmd_done` outside WAIT is ignored.
- Reset mid-operation: all outputs return to reset values on the next edge, including `cmd_valid` dropping mid-handshake. Any write the engine has in flight is abandoned.

## Timing
- Start accepted on edge N: `setup_busy`=1 at N+1; `pwdn` falls at N+1+PWDN_CYCLES; `rstb` rises RST_CYCLES after that.
- First `cmd_valid` rises SETTLE_CYCLES + 2 cycles after `rstb` rises (FETCH + LOAD).
- Per-entry overhead outside the engine: 3 cycles (NEXT, FETCH, LOAD) plus 1 cycle ISSUE minimum.
- `cmd_valid` never drops without a handshake, except on reset.
- `setup_done` and `setup_fail` are mutually exclusive levels.

## Test plan
- Nominal run, PWDN_CYCLES=4, RST_CYCLES=4, SETTLE_CYCLES=8, TBL_LEN=3, ROM {3008_82, 3103_03, 4300_30}, engine always ready, `cmd_done` 5 cycles after each handshake:
  - required: exactly 3 writes, in order, with exact payloads;
  - pwdn/rstb edges at the computed cycles;
  - `setup_done`=1, `setup_busy`=0.
- Backpressure: `cmd_ready` low for 7 cycles → `cmd_valid` and payload held stable for all 7 cycles; a single transfer occurs.
- Retry, MAX_RETRY=3:
  - entry 1 NACKs twice, then ACKs → 3 writes of entry 1, run finishes DONE;
  - entry 1 NACKs 4 times → FAIL, `fail_index`=1, entry 2 never issued.
- Delay entry FFFF_05 with DELAY_UNIT=10 → 50-cycle gap with no `cmd_valid`. Entry FFFF_00 → no gap beyond normal overhead.
- Reset mid-ISSUE (`sys_rst`=0 one cycle) → next edge shows all reset values; a fresh `setup_start` completes normally.
- `setup_start` pulsed during WAIT → ignored. `setup_start` pulsed in DONE → full restart with `pwdn` back to 1.
